// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared FSM state type and constant clog2 helper for the SD port arbiter
package sd_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, DRAIN, DONE} state_t;
  function automatic int clog2(input logic [63:0] v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sd_rr_picker.sv
// sd_rr_picker: combinational round-robin chooser; req vector + ptr in, one-hot gnt + idx of first requester after ptr out
module sd_rr_picker
  import sd_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IW = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IW-1:0]        idx
);
  logic [IW-1:0] pi;
  always_comb begin
    gnt = '0;
    idx = '0;
    pi = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      pi = IW'((int'(ptr) + k) % NUM_PORTS);
      if (req[pi]) begin
        gnt = '0;
        gnt[pi] = 1'b1;
        idx = pi;
      end
    end
  end
endmodule

// File: rtl/sd_port_arb.sv
// sd_port_arb: round-robin multi-client front end for the SD SPI controller; cli_* client ports, ctl_* controller ports, per-request done/timeout-error pulses
module sd_port_arb
  import sd_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        cli_req,
  input  logic [NUM_PORTS-1:0]        cli_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] cli_wdata,
  output logic [NUM_PORTS-1:0]        cli_ack,
  output logic [NUM_PORTS-1:0]        cli_wreq,
  output logic [NUM_PORTS-1:0]        cli_rvalid,
  output logic [DATA_W-1:0]           cli_rdata,
  output logic [NUM_PORTS-1:0]        cli_done,
  output logic [NUM_PORTS-1:0]        cli_err,
  input  logic                        ctl_init_done,
  output logic                        ctl_write_start,
  output logic                        ctl_read_start,
  output logic [ADDR_W-1:0]           ctl_addr,
  output logic [DATA_W-1:0]           ctl_write_data,
  input  logic                        ctl_write_busy,
  input  logic                        ctl_read_busy,
  input  logic                        ctl_write_request,
  input  logic                        ctl_read_enable,
  input  logic [DATA_W-1:0]           ctl_read_data
);
  localparam int IW = clog2(NUM_PORTS);
  localparam int CW = clog2(64'(TIMEOUT_CYC) + 64'd1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);
  state_t state, nxt;
  logic [IW-1:0] g_idx, rr_ptr, pick_idx;
  logic [NUM_PORTS-1:0] g_oh, pick_gnt;
  logic we_q, sbusy, tout, go;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0] tcnt;
  sd_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req(cli_req),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  assign sbusy = we_q ? ctl_write_busy : ctl_read_busy;
  assign tout = tcnt == TMAX;
  assign go = ctl_init_done && !ctl_write_busy && !ctl_read_busy && |cli_req;
  assign ctl_addr = addr_q;
  assign ctl_write_data = cli_wdata[g_idx*DATA_W +: DATA_W];
  assign cli_rdata = ctl_read_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = go ? ISSUE : IDLE;
      ISSUE:     nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = sbusy ? XFER : tout ? IDLE : WAIT_BUSY;
      XFER:      nxt = !sbusy ? DONE : tout ? DRAIN : XFER;
      DRAIN:     nxt = sbusy ? DRAIN : IDLE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    cli_ack = state == ISSUE ? g_oh : '0;
    ctl_write_start = state == ISSUE && we_q;
    ctl_read_start = state == ISSUE && !we_q;
    cli_wreq = state == XFER && ctl_write_request ? g_oh : '0;
    cli_rvalid = state == XFER && ctl_read_enable ? g_oh : '0;
    cli_done = state == DONE ? g_oh : '0;
    cli_err = tout && ((state == WAIT_BUSY && !sbusy) || (state == XFER && sbusy)) ? g_oh : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      g_idx <= '0;
      g_oh <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      tcnt <= '0;
      rr_ptr <= IW'(NUM_PORTS - 1);
    end else begin
      if (state == IDLE && go) begin
        g_idx <= pick_idx;
        g_oh <= pick_gnt;
        we_q <= cli_we[pick_idx];
        addr_q <= cli_addr[pick_idx*ADDR_W +: ADDR_W];
      end
      if (state == ISSUE) tcnt <= '0;
      else if ((state == WAIT_BUSY || state == XFER) && !tout) tcnt <= tcnt + 1'b1;
      if (state == DONE) rr_ptr <= g_idx;
    end
endmodule

// File: tb/tb_sd_port_arb.sv
// tb_sd_port_arb: directed plus randomized self-checking bench for sd_port_arb with a behavioural controller model
module tb_sd_port_arb;
  localparam int NP = 4, AW = 32, DW = 16, T = 300;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [NP-1:0] cli_req, cli_we, cli_ack, cli_wreq, cli_rvalid, cli_done, cli_err;
  logic [NP*AW-1:0] cli_addr;
  logic [NP*DW-1:0] cli_wdata;
  logic [DW-1:0] cli_rdata, ctl_write_data, ctl_read_data;
  logic [AW-1:0] ctl_addr;
  logic ctl_init_done, ctl_write_start, ctl_read_start;
  logic ctl_write_busy, ctl_read_busy, ctl_write_request, ctl_read_enable;
  logic m_act = 1'b0, m_isw = 1'b0, m_str = 1'b0, m_hang = 1'b0;
  logic [DW-1:0] m_rd = '0;
  int m_ph = 0, m_len = 1;
  int checks = 0, failures = 0, last = NP - 1;

  sd_port_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
    .cli_ack(cli_ack), .cli_wreq(cli_wreq), .cli_rvalid(cli_rvalid), .cli_rdata(cli_rdata),
    .cli_done(cli_done), .cli_err(cli_err),
    .ctl_init_done(ctl_init_done), .ctl_write_start(ctl_write_start), .ctl_read_start(ctl_read_start),
    .ctl_addr(ctl_addr), .ctl_write_data(ctl_write_data),
    .ctl_write_busy(ctl_write_busy), .ctl_read_busy(ctl_read_busy),
    .ctl_write_request(ctl_write_request), .ctl_read_enable(ctl_read_enable),
    .ctl_read_data(ctl_read_data)
  );

  // controller model: busy rises after a start, then m_len word strobes (read data = word index), then busy falls
  assign ctl_write_busy = m_act && m_isw;
  assign ctl_read_busy = m_act && !m_isw;
  assign ctl_write_request = m_str && m_isw;
  assign ctl_read_enable = m_str && !m_isw;
  assign ctl_read_data = m_rd;
  always @(posedge clk) begin
    m_str <= 1'b0;
    if (!m_hang && (ctl_write_start || ctl_read_start)) begin
      m_act <= 1'b1;
      m_isw <= ctl_write_start;
      m_ph <= 0;
    end else if (m_act) begin
      if (m_ph < m_len) begin
        m_str <= 1'b1;
        m_rd <= DW'(m_ph);
        m_ph <= m_ph + 1;
      end else m_act <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input logic [NP-1:0] r);
    logic [1:0] pi;
    for (int k = 1; k <= NP; k++) begin
      pi = 2'((last + k) % NP);
      if (r[pi]) return int'(pi);
    end
    return -1;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk(tag, {cli_ack, cli_wreq, cli_rvalid, cli_done, cli_err, ctl_write_start, ctl_read_start, ctl_addr}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last = NP - 1;
  endtask

  task automatic post(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [1:0] pp;
    pp = 2'(port);
    cli_req[pp] = 1'b1;
    cli_we[pp] = we;
    cli_addr[port*AW +: AW] = a;
    cli_wdata[port*DW +: DW] = wd;
  endtask

  // waits for the ack of an already-posted request, then follows it through to done
  task automatic do_xfer(input int port, input int len, input int lat);
    logic [1:0] pp;
    logic [NP-1:0] oh;
    logic ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int n, nw, nr, other;
    pp = 2'(port);
    oh = NP'(1) << port;
    ew = cli_we[pp];
    ea = cli_addr[port*AW +: AW];
    ed = cli_wdata[port*DW +: DW];
    m_len = len;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cli_ack == 0 && n < 5000);
    chk("ack_port", cli_ack, oh);
    if (lat > 0) chk("ack_latency", n, lat);
    chk("start_kind", {ctl_write_start, ctl_read_start}, ew ? 2'b10 : 2'b01);
    chk("ctl_addr", ctl_addr, ea);
    if (ew) chk("ctl_write_data", ctl_write_data, ed);
    cli_req[pp] = 1'b0;
    n = 0; nw = 0; nr = 0; other = 0;
    do begin
      @(negedge clk);
      n++;
      nw += int'(cli_wreq[pp]);
      nr += int'(cli_rvalid[pp]);
      other += $countones(cli_wreq & ~oh) + $countones(cli_rvalid & ~oh);
      if (cli_rvalid[pp]) chk("rdata", cli_rdata, DW'(nr - 1));
    end while (cli_done == 0 && cli_err == 0 && n < len + T + 50);
    chk("done_port", cli_done, oh);
    chk("no_err", cli_err, 0);
    chk("strobe_count", ew ? nw : nr, len);
    chk("cross_strobes", ew ? nr : nw, 0);
    chk("other_ports", other, 0);
    last = port;
  endtask

  initial begin
    int n, acks, k;
    logic [NP-1:0] r;
    cli_req = '0; cli_we = '0; cli_addr = '0; cli_wdata = '0;
    ctl_init_done = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset_outputs");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("idle_outputs");

    post(2, 1'b1, 32'h0000_0100, 16'hBEEF);
    do_xfer(2, 256, 1);

    do_reset();
    post(0, 1'b0, 32'h10, 16'h0);
    post(1, 1'b0, 32'h11, 16'h0);
    post(3, 1'b0, 32'h13, 16'h0);
    do_xfer(0, 4, 1);
    post(0, 1'b0, 32'h20, 16'h0);
    do_xfer(1, 4, 2);
    do_xfer(3, 4, 2);
    do_xfer(0, 4, 2);

    @(negedge clk);
    post(1, 1'b0, 32'h1234_5678, 16'h0);
    do_xfer(1, 256, 1);

    ctl_init_done = 1'b0;
    post(0, 1'b1, 32'hA0, 16'h5A5A);
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      acks += $countones(cli_ack);
    end
    chk("no_ack_without_init", acks, 0);
    ctl_init_done = 1'b1;
    do_xfer(0, 3, 1);

    m_hang = 1'b1;
    post(0, 1'b1, 32'hB0, 16'h1111);
    n = 0;
    do begin @(negedge clk); n++; end while (cli_ack == 0 && n < 100);
    chk("tmo_wait_ack", cli_ack, 4'b0001);
    cli_req[0] = 1'b0;
    n = 0; acks = 0;
    do begin @(negedge clk); n++; acks += $countones(cli_done); end while (cli_err == 0 && n < T + 20);
    chk("tmo_wait_cycle", n, T + 1);
    chk("tmo_wait_err", cli_err, 4'b0001);
    chk("tmo_wait_no_done", acks, 0);
    m_hang = 1'b0;
    post(0, 1'b0, 32'hB1, 16'h0);
    do_xfer(0, 5, 2);

    post(1, 1'b1, 32'hC0, 16'h2222);
    m_len = T + 50;
    n = 0;
    do begin @(negedge clk); n++; end while (cli_ack == 0 && n < 100);
    chk("tmo_xfer_ack", cli_ack, 4'b0010);
    cli_req[1] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (cli_err == 0 && n < T + 20);
    chk("tmo_xfer_cycle", n, T + 1);
    chk("tmo_xfer_err", cli_err, 4'b0010);
    acks = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      acks += $countones(cli_wreq) + $countones(cli_done) + $countones(cli_err);
    end while (ctl_write_busy && n < 200);
    chk("drain_silent", acks, 0);
    last = 0;
    post(3, 1'b0, 32'hC1, 16'h0);
    do_xfer(3, 2, 0);

    @(negedge clk);
    post(3, 1'b1, 32'hD0, 16'h3333);
    m_len = 256;
    n = 0;
    do begin @(negedge clk); n++; end while (cli_ack == 0 && n < 100);
    chk("rst_mid_ack", cli_ack, 4'b1000);
    cli_req[3] = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_idle_outputs("rst_mid_outputs");
    @(negedge clk);
    reset = 1'b0;
    last = NP - 1;
    post(2, 1'b0, 32'hD1, 16'h0);
    acks = 0; n = 0;
    while (ctl_write_busy && n < 400) begin
      @(negedge clk);
      n++;
      acks += int'(ctl_write_start) + int'(ctl_read_start);
    end
    chk("no_start_while_busy", acks, 0);
    do_xfer(2, 3, 0);

    for (int round = 0; round < 30; round++) begin
      for (int p = 0; p < NP; p++) begin
        k = int'($urandom_range(0, 1));
        r = cli_req;
        if (!r[2'(p)] && (k == 1 || p == round % NP))
          post(p, 1'($urandom_range(0, 1)), $urandom(), 16'($urandom()));
      end
      do_xfer(exp_grant(cli_req), int'($urandom_range(1, 6)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_port_arb.md
# sd_port_arb

Parametrised multi-client front end for the SD card SPI controller top level. Up to NUM_PORTS clients each post single-sector read or write requests. The block arbitrates between them round-robin and drives the controller's start/address lines. For the granted client, it routes word requests, write data and read data between the client and the controller. It adds per-request completion and timeout error reporting, which the single-user controller lacks.

## Interface
- NUM_PORTS, 4, number of client ports (2..8)
- ADDR_W, 32, sector address width
- DATA_W, 16, data word width; must equal the controller word width
- TIMEOUT_CYC, 2_000_000, max cycles from start pulse to busy fall before error
- clk  in  1  system clock; the controller's clk
- reset  in  1  asynchronous, active-high reset
- cli_req  in  NUM_PORTS  request level per client; held until ack
- cli_we  in  NUM_PORTS  1 = write sector, 0 = read sector; sampled with req
- cli_addr  in  NUM_PORTS*ADDR_W  packed sector addresses, port p at [p*ADDR_W +: ADDR_W]
- cli_wdata  in  NUM_PORTS*DATA_W  packed write words
- cli_ack  out  NUM_PORTS  one-cycle pulse: request accepted
- cli_wreq  out  NUM_PORTS  write-word request, granted port only
- cli_rvalid  out  NUM_PORTS  read word valid, granted port only
- cli_rdata  out  DATA_W  read word, shared by all ports
- cli_done  out  NUM_PORTS  one-cycle pulse: transfer completed
- cli_err  out  NUM_PORTS  one-cycle pulse: transfer timed out
- ctl_init_done  in  1  controller initialisation complete
- ctl_write_start / ctl_read_start  out  1 each  one-cycle start pulses
- ctl_addr  out  ADDR_W  latched sector address; drives both write and read address inputs
- ctl_write_data  out  DATA_W  granted client's cli_wdata slice
- ctl_write_busy / ctl_read_busy  in  1 each  controller busy flags
- ctl_write_request / ctl_read_enable  in  1 each  controller word strobes
- ctl_read_data  in  DATA_W  controller read word

## Operation
- FSM states are IDLE, ISSUE, WAIT_BUSY, XFER, DRAIN, DONE.
- IDLE:
  - Advances to ISSUE when ctl_init_done=1, both busy flags are 0, and any cli_req bit is 1.
  - Grant = first requesting port after rr_ptr, searching upward with wrap at NUM_PORTS.
  - Grant index, cli_we and cli_addr are latched.
- ISSUE (1 cycle):
  - cli_ack[g]=1.
  - ctl_write_start=1 if we, else ctl_read_start=1.
  - Timeout counter cleared.
  - Next state is WAIT_BUSY.
- WAIT_BUSY:
  - Waits for the selected busy flag to be 1, then goes to XFER.
  - On counter reaching TIMEOUT_CYC: cli_err[g] pulses and the FSM returns to IDLE.
- XFER:
  - cli_wreq[g] = ctl_write_request; cli_rvalid[g] = ctl_read_enable.
  - All other ports see 0.
  - On busy 1→0: go to DONE.
  - On timeout: cli_err[g] pulses and the FSM goes to DRAIN.
- DRAIN:
  - No routing.
  - Waits for busy 0, then goes to IDLE. This state has no timeout.
- DONE (1 cycle): cli_done[g]=1, rr_ptr←g, next state IDLE.
- ctl_write_data = cli_wdata slice of the latched grant (combinational). cli_rdata = ctl_read_data (combinational).
- The timeout counter is ceil(log2(TIMEOUT_CYC+1)) bits, increments in WAIT_BUSY/XFER, and saturates.
- A req dropped before ack is simply not granted. A req reasserted in the DONE cycle is eligible in the next IDLE.
- ctl_init_done falling mid-transfer is ignored; only IDLE checks it.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - rr_ptr = NUM_PORTS-1, so port 0 wins first.
  - Latched address and grant are 0.
- Latency: req sampled in IDLE at cycle N; ack and start at N+1.
- Gap: at least 2 idle cycles (DONE, IDLE) between one done pulse and the next ack.
- Simultaneous requests: exactly one ack per grant. Fairness is strict rotation starting after the last completed port.
- Busy already 1 in IDLE (for example after reset during a transfer): no issue until busy is 0.
- Timed-out ports do not update rr_ptr.

## Structure
- Package sd_arb_pkg holds the state enum and the helper function clog2.
- Sub-module sd_rr_picker: combinational round-robin chooser. Inputs are request vector and rr_ptr; outputs are one-hot grant and index. It is also used standalone by verification.

## Test plan
- Single port 2 write, addr 0x0000_0100:
  - ack[2] comes 1 cycle after IDLE sampling, and ctl_write_start pulses with ctl_addr=0x100.
  - 256 ctl_write_request strobes appear on cli_wreq[2] only.
  - done[2] follows the busy fall.
- Ports 0,1,3 request reads simultaneously: grants go in order 0,1,3. Then port 0 re-requests: grant goes to 0 only after 3.
- Read of 256 words from a model returning data=index: port 1 sees 256 rvalid pulses with cli_rdata 0..255, and rvalid stays 0 on other ports.
- ctl_init_done held 0 for 1000 cycles with req[0]=1: no ack. Raise init_done: ack follows in ≤2 cycles.
- Model never raises busy, TIMEOUT_CYC=100: err[0] at cycle 101 after start, no done, and the next request is serviced normally.
- Reset asserted mid-XFER while the model keeps busy=1: outputs go to 0 immediately. After release, no start is issued until busy falls.
